// File: rtl/bcd_counter_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_7seg_mux
// Purpose  : Decimal (BCD) up/down counter advancing at COUNT_HZ, with a
//            multiplexed DIGITS-wide active-low 7-segment display driver
//            scanning at SCAN_HZ per digit. The units digit is mirrored on the
//            LEDs (active-low binary). WRAP pulses for one cycle when the
//            count rolls over (all-9s -> all-0s or all-0s -> all-9s).
// Ports    : CLOCK_50 - board clock, rising edge
//            RESET    - asynchronous active-high reset
//            EN       - count enable (freezes count and count prescaler)
//            UP       - count direction, 1 = up, 0 = down
//            CLR      - synchronous clear of count and count prescaler
//            LED[3:0] - ~units digit, registered
//            DIG[]    - one-hot active-low tube select, bit 0 = units
//            SEG[6:0] - active-low segments {g,f,e,d,c,b,a}
//            WRAP     - one-cycle rollover pulse
// Options  : LEADING_ZERO_BLANK_EN - when defined, leading zero digits are
//            blanked (units digit always shown).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_7seg_mux #(
  parameter int CLK_HZ   = 50000000,
  parameter int COUNT_HZ = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              EN,
  input  logic              UP,
  input  logic              CLR,
  output logic [3:0]        LED,
  output logic [DIGITS-1:0] DIG,
  output logic [6:0]        SEG,
  output logic              WRAP
);

  localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int CNT_W    = $clog2(CNT_DIV);
  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Count prescaler: tick on the enabled cycle it wraps back to zero
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_pre;
  logic             count_tick;

  assign count_tick = EN && (cnt_pre == CNT_LAST);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_pre <= '0;
    end else if (CLR) begin
      cnt_pre <= '0;
    end else if (EN) begin
      cnt_pre <= count_tick ? '0 : cnt_pre + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // BCD next-value: ripple carry/borrow from the units digit upward. If the
  // chain survives past the top digit the whole count has rolled over.
  // --------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] count;
  logic [DIGITS-1:0][3:0] count_nxt;
  logic                   roll;

  always_comb begin
    count_nxt = count;
    roll      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (roll) begin
        if (UP) begin
          if (count[i] >= 4'd9) begin
            count_nxt[i] = 4'd0;
          end else begin
            count_nxt[i] = count[i] + 4'd1;
            roll         = 1'b0;
          end
        end else begin
          if (count[i] == 4'd0) begin
            count_nxt[i] = 4'd9;
          end else begin
            count_nxt[i] = count[i] - 4'd1;
            roll         = 1'b0;
          end
        end
      end
    end
  end

  // CLR wins over a coincident tick and suppresses the wrap pulse.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      count <= '0;
      WRAP  <= 1'b0;
      LED   <= 4'hF;
    end else begin
      LED <= ~count[0];
      if (CLR) begin
        count <= '0;
        WRAP  <= 1'b0;
      end else begin
        WRAP <= count_tick && roll;
        if (count_tick) begin
          count <= count_nxt;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero blanking for the currently selected slot
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic             blank_sel;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  always_comb begin
    logic all_zero;
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (count[i] == 4'd0);
      lead_zero[i] = all_zero;
    end
    lead_zero[0] = 1'b0;  // units digit is always displayed
  end

  assign blank_sel = lead_zero[idx];
`else
  assign blank_sel = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Scan: free-running prescaler; DIG and SEG load together on a scan tick so
  // a tube is never enabled with the previous tube's segment pattern.
  // --------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_pre;
  logic              scan_tick;

  assign scan_tick = (scan_pre == SCAN_LAST);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      scan_pre <= '0;
      idx      <= '0;
      DIG      <= '1;
      SEG      <= 7'h7F;
    end else begin
      scan_pre <= scan_tick ? '0 : scan_pre + 1'b1;
      if (scan_tick) begin
        DIG <= ~(DIGITS'(1) << idx);
        SEG <= blank_sel ? 7'h7F : seg_decode(count[idx]);
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_7seg_mux
// Purpose  : Directed self-checking bench for bcd_counter_7seg_mux with
//            CLK_HZ=100, COUNT_HZ=10, SCAN_HZ=5, DIGITS=2 (count tick and
//            scan tick every 10 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_counter_7seg_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] led;
  logic [1:0] dig;
  logic [6:0] seg;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  bcd_counter_7seg_mux #(
    .CLK_HZ  (100),
    .COUNT_HZ(10),
    .SCAN_HZ (5),
    .DIGITS  (2)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .EN      (en),
    .UP      (up),
    .CLR     (clr),
    .LED     (led),
    .DIG     (dig),
    .SEG     (seg),
    .WRAP    (wrap)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 ns after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // With the count frozen, let two full scan rounds flush stale values, then
  // capture the pattern shown in each slot. ok = 0 if a slot never appears.
  task automatic read_display(output logic [6:0] s_units, output logic [6:0] s_tens,
                              output bit ok);
    bit got_u, got_t;
    got_u = 0; got_t = 0; s_units = 7'h7F; s_tens = 7'h7F;
    step(20);
    for (int k = 0; k < 25; k++) begin
      if (dig == 2'b10) begin s_units = seg; got_u = 1; end
      if (dig == 2'b01) begin s_tens  = seg; got_t = 1; end
      step(1);
    end
    ok = got_u && got_t;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    step(3);
    tests++; if (led !== 4'b1111) begin fails++; $display("FAIL reset_led got %b want 1111", led); end
    tests++; if (dig !== 2'b11)   begin fails++; $display("FAIL reset_dig got %b want 11", dig); end
    tests++; if (seg !== 7'h7F)   begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
    tests++; if (wrap !== 1'b0)   begin fails++; $display("FAIL reset_wrap got %b want 0", wrap); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [6:0] su, st; bit ok;
    en = 1'b1; up = 1'b1;
    step(100);                        // 10 ticks -> count 10
    en = 1'b0;
    step(1);
    tests++; if (led !== 4'b1111) begin fails++; $display("FAIL up10_led got %b want 1111", led); end
    read_display(su, st, ok);
    tests++; if (!ok)        begin fails++; $display("FAIL up10_scan_timeout got 0 want 1"); end
    tests++; if (su !== 7'h40) begin fails++; $display("FAIL up10_units_seg got %h want 40", su); end
    tests++; if (st !== 7'h79) begin fails++; $display("FAIL up10_tens_seg got %h want 79", st); end
    en = 1'b1;
    step(850);                        // 85 more ticks -> count 95
    en = 1'b0;
    step(1);
    tests++; if (led !== 4'b1010) begin fails++; $display("FAIL up95_led got %b want 1010", led); end
    read_display(su, st, ok);
    tests++; if (su !== 7'h12 || st !== 7'h10 || !ok)
      begin fails++; $display("FAIL up95_seg got %h/%h want 12/10", su, st); end
  endtask

  task automatic test_wrap();
    // count is 95 with the prescaler at 0
    en = 1'b1; up = 1'b1;
    step(49);                         // count 99, prescaler at 9
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_pre_up got %b want 0", wrap); end
    step(1);                          // 99 -> 00
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL wrap_up_pulse got %b want 1", wrap); end
    tests++; if (led !== 4'b0110) begin fails++; $display("FAIL wrap_up_led_lag got %b want 0110", led); end
    up = 1'b0;
    step(1);
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_up_width got %b want 0", wrap); end
    tests++; if (led !== 4'b1111) begin fails++; $display("FAIL wrap_up_led got %b want 1111", led); end
    step(8);
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_pre_down got %b want 0", wrap); end
    step(1);                          // 00 -> 99
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL wrap_down_pulse got %b want 1", wrap); end
    step(1);
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_down_width got %b want 0", wrap); end
    tests++; if (led !== 4'b0110) begin fails++; $display("FAIL wrap_down_led got %b want 0110", led); end
  endtask

  task automatic test_enable_hold();
    int bad; bit seen_u, seen_t;
    do_reset();
    en = 1'b1; up = 1'b1;
    step(420);                        // count 42
    en = 1'b0;
    bad = 0; seen_u = 0; seen_t = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (wrap !== 1'b0) bad++;
      if (dig == 2'b10) begin seen_u = 1; if (seg !== 7'h24) bad++; end
      else if (dig == 2'b01) begin seen_t = 1; if (seg !== 7'h19) bad++; end
      else bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_scan got %0d bad cycles want 0", bad); end
    tests++; if (!(seen_u && seen_t)) begin fails++; $display("FAIL hold_alternate got %b%b want 11", seen_u, seen_t); end
    tests++; if (led !== 4'b1101) begin fails++; $display("FAIL hold_led got %b want 1101", led); end
  endtask

  task automatic test_clear();
    do_reset();
    en = 1'b1; up = 1'b1;
    step(370);                        // count 37
    step(9);                          // next edge is a tick
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL clr_wrap got %b want 0", wrap); end
    step(1);
    tests++; if (led !== 4'b1111) begin fails++; $display("FAIL clr_led got %b want 1111", led); end
    step(8);                          // 9 cycles after CLR: no tick yet
    tests++; if (led !== 4'b1111) begin fails++; $display("FAIL clr_early_tick got %b want 1111", led); end
    step(2);                          // tick at CLR+10, LED one later
    tests++; if (led !== 4'b1110) begin fails++; $display("FAIL clr_next_tick got %b want 1110", led); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; up = 1'b1;
    step(585);                        // count 58, mid-scan
    tests++; if (led !== 4'b0111) begin fails++; $display("FAIL pre_rst_led got %b want 0111", led); end
    rst = 1'b1;
    #1;                               // no clock edge in between
    tests++; if (dig !== 2'b11 || seg !== 7'h7F || led !== 4'b1111)
      begin fails++; $display("FAIL async_rst got %b/%h/%b want 11/7f/1111", dig, seg, led); end
    en = 1'b0;
    step(2);
    rst = 1'b0;
    step(9);
    tests++; if (dig !== 2'b11) begin fails++; $display("FAIL rst_scan_early got %b want 11", dig); end
    step(1);
    tests++; if (dig !== 2'b10 || seg !== 7'h40)
      begin fails++; $display("FAIL rst_first_scan got %b/%h want 10/40", dig, seg); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] su, st; bit ok;
    logic [6:0] exp_t;
`ifdef LEADING_ZERO_BLANK_EN
    exp_t = 7'h7F;
`else
    exp_t = 7'h40;
`endif
    do_reset();
    en = 1'b1; up = 1'b1;
    step(70);                         // count 07
    en = 1'b0;
    read_display(su, st, ok);
    tests++; if (!ok)          begin fails++; $display("FAIL lz_scan_timeout got 0 want 1"); end
    tests++; if (su !== 7'h78) begin fails++; $display("FAIL lz_units_seg got %h want 78", su); end
    tests++; if (st !== exp_t) begin fails++; $display("FAIL lz_tens_seg got %h want %h", st, exp_t); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    test_reset();
    test_count_up();
    test_wrap();
    test_enable_hold();
    test_clear();
    test_async_reset();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
